// File: rtl/mux8way16_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 8-input mux.
// Grants one requester at a time and caps consecutive beats at MAX_HOLD
// whenever someone else is waiting. The selected data is registered onto out.
module mux8way16_rr_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [7:0]       gnt,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [2:0]       out_src
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e           r_state, w_state_d;
  logic [7:0]       r_gnt, w_gnt_d;
  logic [2:0]       r_sel, w_sel_d;
  logic [2:0]       r_ptr, w_ptr_d;
  logic [7:0]       r_hold, w_hold_d;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic [2:0]       r_src;

  logic             w_beat;
  logic [7:0]       w_others;
  logic [3:0]       w_pick;
  logic             w_grant;
  logic [WIDTH-1:0] w_mux;

  // First set bit of reqs searching upward from start with 7->0 wrap.
  // Result is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] reqs, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    // Descending scan so the smallest offset from start is written last.
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (reqs[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_beat   = |(r_gnt & req);
  // Holder is excluded; in IDLE or on release this equals req itself.
  assign w_others = req & ~r_gnt;
  assign w_pick   = rr_pick(w_others, r_ptr);

  // Next grant, pointer, hold count and state.
  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    w_hold_d  = r_hold;
    w_grant   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|req) w_grant = 1'b1;
      end
      StBusy: begin
        if (w_beat) begin
          if (r_hold != HoldLast) begin
            w_hold_d = r_hold + 8'd1;
          end else if (|w_others) begin
            w_grant = 1'b1;
          end else begin
            // Nobody waiting: keep streaming and start a fresh hold window.
            w_hold_d = '0;
          end
        end else if (|req) begin
          w_grant = 1'b1;
        end else begin
          w_gnt_d   = '0;
          w_state_d = StIdle;
          w_hold_d  = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_grant) begin
      w_gnt_d   = 8'b1 << w_pick[2:0];
      w_sel_d   = w_pick[2:0];
      w_ptr_d   = w_pick[2:0] + 3'd1;
      w_hold_d  = '0;
      w_state_d = StBusy;
    end
  end

  // Shared data mux steered by the registered select.
  always_comb begin
    w_mux = a;
    unique case (r_sel)
      3'd0: w_mux = a;
      3'd1: w_mux = b;
      3'd2: w_mux = c;
      3'd3: w_mux = d;
      3'd4: w_mux = e;
      3'd5: w_mux = f;
      3'd6: w_mux = g;
      3'd7: w_mux = h;
      default: w_mux = a;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_sel   <= w_sel_d;
      r_ptr   <= w_ptr_d;
      r_hold  <= w_hold_d;
    end
  end

  // Output bus registers; data and source hold between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
    end else begin
      r_valid <= w_beat;
      if (w_beat) begin
        r_out <= w_mux;
        r_src <= r_sel;
      end
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign out_src   = r_src;

endmodule

// File: tb/tb_mux8way16_rr_arbiter.sv
// Bench for the round-robin mux arbiter: per-cycle vector table with a beat
// scoreboard on a MAX_HOLD=4 instance, plus hand-written reset and MAX_HOLD=1 sequences.
module tb_mux8way16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  req = '0;
  logic [15:0] a, b, c, d, e, f, g, h;

  logic [7:0]  gnt, gnt1;
  logic [2:0]  sel, sel1;
  logic [15:0] out, out1;
  logic        out_valid, out_valid1;
  logic [2:0]  out_src, out_src1;

  always #5 clk = ~clk;

  mux8way16_rr_arbiter #(.WIDTH(16), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid), .out_src(out_src)
  );

  mux8way16_rr_arbiter #(.WIDTH(16), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .gnt(gnt1), .sel(sel1), .out(out1), .out_valid(out_valid1), .out_src(out_src1)
  );

  typedef struct {
    bit          do_rst;
    logic [7:0]  req;
    logic [15:0] base;
    logic [7:0]  exp_gnt;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [2:0]  src;
    logic [15:0] data;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input bit rs, input logic [7:0] rq, input logic [15:0] base,
                         input logic [7:0] eg, input logic ev);
    vec_t v;
    v.do_rst = rs; v.req = rq; v.base = base; v.exp_gnt = eg; v.exp_valid = ev;
    vecs.push_back(v);
  endtask

  // Requester i drives base + i.
  task automatic set_data(input logic [15:0] base);
    a = base;          b = base + 16'd1; c = base + 16'd2; d = base + 16'd3;
    e = base + 16'd4;  f = base + 16'd5; g = base + 16'd6; h = base + 16'd7;
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rst_n = 1'b0;
    #2;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] prev_gnt;
    beat_t      bt;

    // Single requester c=0xBEEF; grant never drops while alone.
    add_vec(1, 8'h04, 16'hBEED, 8'h04, 0);
    for (int i = 0; i < 5; i++) add_vec(0, 8'h04, 16'hBEED, 8'h04, 1);
    add_vec(0, 8'h00, 16'hBEED, 8'h00, 0);
    add_vec(0, 8'h00, 16'hBEED, 8'h00, 0);
    // Fairness 0 vs 7, four beats each, no idle cycle between grants.
    add_vec(1, 8'h81, 16'h1000, 8'h01, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 8'h81, 16'h1000, 8'h01, 1);
    add_vec(0, 8'h81, 16'h1000, 8'h80, 1);
    for (int i = 0; i < 3; i++) add_vec(0, 8'h81, 16'h1000, 8'h80, 1);
    add_vec(0, 8'h81, 16'h1000, 8'h01, 1);
    add_vec(0, 8'h81, 16'h1000, 8'h01, 1);
    add_vec(0, 8'h00, 16'h1000, 8'h00, 0);
    // Release handoff 5 -> 1 after two beats.
    add_vec(1, 8'h20, 16'h2000, 8'h20, 0);
    add_vec(0, 8'h22, 16'h2000, 8'h20, 1);
    add_vec(0, 8'h22, 16'h2000, 8'h20, 1);
    add_vec(0, 8'h02, 16'h2000, 8'h02, 0);
    add_vec(0, 8'h02, 16'h2000, 8'h02, 1);
    add_vec(0, 8'h00, 16'h2000, 8'h00, 0);
    // Pointer wrap: last winner 6, then req 0x41 picks 0 before 6.
    add_vec(1, 8'h40, 16'h5000, 8'h40, 0);
    add_vec(0, 8'h00, 16'h5000, 8'h00, 0);
    add_vec(0, 8'h41, 16'h5000, 8'h01, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 8'h41, 16'h5000, 8'h01, 1);
    add_vec(0, 8'h41, 16'h5000, 8'h40, 1);
    add_vec(0, 8'h41, 16'h5000, 8'h40, 1);
    add_vec(0, 8'h00, 16'h5000, 8'h00, 0);

    set_data(16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_src", 32'(out_src), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a stream from requester 3.
    @(negedge clk);
    req = 8'h08;
    set_data(16'h1231);
    repeat (3) @(posedge clk);
    #1;
    check("mid_gnt", 32'(gnt), 32'h08);
    check("mid_valid", 32'(out_valid), 32'h1);
    check("mid_out", 32'(out), 32'h1234);
    check("mid_src", 32'(out_src), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_sel", 32'(sel), 32'h0);
    check("async_out", 32'(out), 32'h0);
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_src", 32'(out_src), 32'h0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table with beat scoreboard.
    prev_gnt = '0;
    foreach (vecs[n]) begin
      if (vecs[n].do_rst) begin
        do_reset();
        prev_gnt = '0;
      end
      @(negedge clk);
      req = vecs[n].req;
      set_data(vecs[n].base);
      if ((prev_gnt & vecs[n].req) != 8'h00) begin
        bt.src  = idx_of(prev_gnt);
        bt.data = vecs[n].base + 16'(idx_of(prev_gnt));
        sb.push_back(bt);
      end
      @(posedge clk);
      #1;
      check($sformatf("r%0d_gnt", n), 32'(gnt), 32'(vecs[n].exp_gnt));
      check($sformatf("r%0d_valid", n), 32'(out_valid), 32'(vecs[n].exp_valid));
      check($sformatf("r%0d_onehot", n), 32'($onehot0(gnt)), 32'h1);
      if (vecs[n].exp_gnt != 8'h00)
        check($sformatf("r%0d_sel", n), 32'(sel), 32'(idx_of(vecs[n].exp_gnt)));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check($sformatf("r%0d_sb_extra", n), 32'h1, 32'h0);
        end else begin
          bt = sb.pop_front();
          check($sformatf("r%0d_sb_out", n), 32'(out), 32'(bt.data));
          check($sformatf("r%0d_sb_src", n), 32'(out_src), 32'(bt.src));
        end
      end
      prev_gnt = vecs[n].exp_gnt;
    end
    check("sb_empty", 32'(sb.size()), 32'h0);

    // MAX_HOLD=1 with all eight requesting: strict rotation 0..7,0.
    do_reset();
    @(negedge clk);
    req = 8'hFF;
    set_data(16'h0000);
    @(posedge clk);
    #1;
    check("rot_first_gnt", 32'(gnt1), 32'h01);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rot%0d_valid", k), 32'(out_valid1), 32'h1);
      check($sformatf("rot%0d_src", k), 32'(out_src1), 32'(k % 8));
      check($sformatf("rot%0d_out", k), 32'(out1), 32'(k % 8));
      check($sformatf("rot%0d_gnt", k), 32'(gnt1), 32'(8'h01 << ((k + 1) % 8)));
      check($sformatf("rot%0d_onehot", k), 32'($onehot(gnt1)), 32'h1);
    end
    @(negedge clk);
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8way16_rr_arbiter.md
Name: mux8way16_rr_arbiter

Overview:
Round-robin arbiter that shares one 16-bit, 8-input mux datapath among eight requesters. It owns the 3-bit select that steers a..h to a single registered output, and it enforces a per-grant beat limit so that no requester starves the others. It sits between eight producer ports and one shared 16-bit consumer bus, and is the sequencing front-end for the 8-way 16-bit mux.

Parameters:
WIDTH, 16, data width of every input and of out
MAX_HOLD, 4, max consecutive beats one requester keeps the grant while others are waiting; legal range 1..255

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
req  input  8  req[i] high = requester i has a beat to send this cycle
a,b,c,d,e,f,g,h  input  WIDTH each  data of requesters 0..7
gnt  output  8  one-hot registered grant; all-zero when idle
sel  output  3  registered mux select = index of gnt bit; holds last value when idle
out  output  WIDTH  registered shared-bus data
out_valid  output  1  out carries a transferred beat this cycle
out_src  output  3  index of the requester whose beat is on out

Behaviour:
- Reset (rst_n low, async, any time including mid-grant): gnt=0, sel=0, out=0, out_valid=0, out_src=0, state=IDLE, ptr=0, hold_cnt=0. Operation resumes on the first rising edge after rst_n goes high.
- Beat: any cycle with gnt[i] & req[i] at the rising edge.
  - On that edge, out <= input i (selected via the current sel), out_src <= i, out_valid <= 1.
  - Latency from beat to out_valid is 1 cycle.
  - out_valid <= 0 on every edge with no beat. out and out_src hold their values when there is no beat.
- Priority search: starts at index ptr and wraps 7->0. The first asserted req bit wins. ptr <= winner+1 (mod 8) on every new grant.
- IDLE:
  - If req != 0, on the next edge: gnt <= onehot(winner), sel <= winner, hold_cnt <= 0, state <= BUSY.
  - Grant latency is 1 cycle from req. No beat occurs in the grant cycle because gnt was 0.
- BUSY, holder i:
  - Beat with hold_cnt < MAX_HOLD-1: keep grant, hold_cnt++.
  - Beat with hold_cnt == MAX_HOLD-1 and any other req[j] high (j != i): rearbitrate from ptr (= i+1) on the same edge, excluding i. gnt moves directly to the new winner with no idle bubble, hold_cnt <= 0.
  - Beat with hold_cnt == MAX_HOLD-1 and no other requester: keep grant, hold_cnt <= 0, so i keeps streaming.
  - req[i] low (release): the edge performs no beat. If any other req is high, grant the search winner from ptr on that edge (no bubble). Otherwise gnt <= 0, state <= IDLE, sel unchanged.
- Simultaneous requests: only round-robin order decides. Lower index has no fixed priority.
- Invariants:
  - gnt is zero or one-hot at all times.
  - sel == index(gnt) whenever gnt != 0.
  - out_valid never high two cycles after the last beat.
- Width rules: hold_cnt is 8 bits. ptr and indices are 3 bits with natural wrap (7+1 = 0).

Test Plan:
1. Reset mid-stream: requester 3 streaming 0x1234; pull rst_n low between edges -> gnt, sel, out, out_valid, out_src read 0 immediately, without waiting for a clock edge.
2. Single requester: after reset, req=0x04, c=0xBEEF held 6 cycles -> gnt=0x04 and sel=2 one cycle later; out_valid high from the following cycle with out=0xBEEF, out_src=2; the grant never drops while no one else requests.
3. Fairness at MAX_HOLD=4: req=0x81 held continuously, ptr=0 -> requester 0 gets 4 beats, then gnt=0x80 for 4 beats, then back to 0x01, with no idle cycle between grants.
4. Release handoff: holder 5 drops req after 2 beats while req[1] is high -> gnt goes 0x20 -> 0x02 on the release edge; out_valid is low for exactly one cycle.
5. Wrap-around: ptr=7 (last winner 6), req=0x41 -> winner is 0 (search order 7,0,…), then 6; confirms ptr wraps 7->0.
6. All eight request with data a=0x0000 … h=0x0007 at MAX_HOLD=1 -> out_src sequence 0,1,…,7,0 on successive beats; out equals out_src; gnt stays one-hot throughout.
